// File: rtl/wb_pkg.sv
// Shared widths and constants for the write-back stage and its register file.
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 15;

  localparam logic [ADDR_W-1:0] REG_PC      = 4'd15;
  localparam logic [DATA_W-1:0] REG_RST_VAL = '0;

  // R15 is the PC and is owned by the fetch stage, never by this register file.
  function automatic logic is_pc(input logic [ADDR_W-1:0] idx);
    return idx == REG_PC;
  endfunction

endpackage

// File: rtl/wb_stage_reg_file.sv
// Architectural register file R0..R14: one synchronous write port, three
// combinational read ports, async active-low reset. Index 15 reads as zero.
module reg_file
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rn_addr,
  input  logic [ADDR_W-1:0] rm_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] view [2**ADDR_W];

  // NOTE: this array is built from flops, not a RAM macro, so it can and must be
  // reset; sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RST_VAL;
    end else begin
      // Per-entry compare keeps an unknown index from selecting any entry.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && waddr == ADDR_W'(i)) regs[i] <= wdata;
      end
    end
  end

  // Full 16-entry view so every 4-bit index has a defined read value.
  for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_view
    if (g < NUM_REGS) begin : g_reg
      assign view[g] = regs[g];
    end else begin : g_zero
      assign view[g] = REG_RST_VAL;
    end
  end

  assign rn_data = view[rn_addr];
  assign rm_data = view[rm_addr];
  assign rd_data = view[rd_addr];

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: result select, R15 filtering, register-file commit and
// retire counter. Define WB_BYPASS_EN for same-cycle write-through reads.
module wb_stage
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_res_in,
  input  logic [ADDR_W-1:0] rn_addr,
  input  logic [ADDR_W-1:0] rm_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wb_value,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_valid,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] rf_rn;
  logic [DATA_W-1:0] rf_rm;
  logic [DATA_W-1:0] rf_rd;
  logic [31:0]       retire_q;

  assign wb_value = mem_r_en_in ? mem_res_in : alu_res_in;
  assign wb_dest  = dest_in;
  assign wb_valid = wb_en_in && !is_pc(dest_in);

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_valid),
    .waddr   (dest_in),
    .wdata   (wb_value),
    .rn_addr (rn_addr),
    .rm_addr (rm_addr),
    .rd_addr (rd_addr),
    .rn_data (rf_rn),
    .rm_data (rf_rm),
    .rd_data (rf_rd)
  );

  // NOTE: every output of this always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    rn_data = rf_rn;
    rm_data = rf_rm;
    rd_data = rf_rd;
`ifdef WB_BYPASS_EN
    if (wb_valid && rn_addr == dest_in) rn_data = wb_value;
    if (wb_valid && rm_addr == dest_in) rm_data = wb_value;
    if (wb_valid && rd_addr == dest_in) rd_data = wb_value;
`else
    // Stored value only; the hazard unit stalls on a WB-to-ID dependency.
`endif
  end

  // Free-running modulo-2^32 count of committed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_q <= '0;
    else if (wb_valid) retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of committed writes plus a
// register-file model; honours WB_BYPASS_EN for same-cycle read expectations.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in;
  logic [31:0] mem_res_in;
  logic [3:0]  rn_addr, rm_addr, rd_addr;
  logic [31:0] rn_data, rm_data, rd_data;
  logic [31:0] wb_value;
  logic [3:0]  wb_dest;
  logic        wb_valid;
  logic [31:0] retire_cnt;

  wb_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en_in    (wb_en_in),
    .mem_r_en_in (mem_r_en_in),
    .dest_in     (dest_in),
    .alu_res_in  (alu_res_in),
    .mem_res_in  (mem_res_in),
    .rn_addr     (rn_addr),
    .rm_addr     (rm_addr),
    .rd_addr     (rd_addr),
    .rn_data     (rn_data),
    .rm_data     (rm_data),
    .rd_data     (rd_data),
    .wb_value    (wb_value),
    .wb_dest     (wb_dest),
    .wb_valid    (wb_valid),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] regs_m [16];
  logic [31:0] cnt_m;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        cur_valid;
  logic [3:0]  cur_dest;
  logic [31:0] cur_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one MEM/WB beat (caller is just after a falling edge) and check the
  // combinational write-back bus against the model.
  task automatic drive(input logic en, input logic sel, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] mem);
    logic [31:0] v;
    logic        ok;
    wb_en_in    = en;
    mem_r_en_in = sel;
    dest_in     = dest;
    alu_res_in  = alu;
    mem_res_in  = mem;
    #1;
    v  = sel ? mem : alu;
    ok = en && (dest != 4'd15);
    check("wb_value", wb_value, v);
    check("wb_dest", {28'd0, wb_dest}, {28'd0, dest});
    check("wb_valid", {31'd0, wb_valid}, {31'd0, ok});
    cur_valid = ok;
    cur_dest  = dest;
    cur_val   = v;
    if (ok) sb.push_back('{dest, v});
  endtask

  // Let the rising edge commit, then pop the scoreboard and read it back.
  task automatic commit();
    wr_t e;
    @(posedge clk);
    if (cur_valid) begin
      regs_m[cur_dest] = cur_val;
      cnt_m++;
    end
    cur_valid = 1'b0;
    @(negedge clk);
    wb_en_in = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rn_addr = e.addr;
      rm_addr = e.addr;
      rd_addr = e.addr;
      #1;
      check("rn_commit", rn_data, e.data);
      check("rm_commit", rm_data, e.data);
      check("rd_commit", rd_data, e.data);
    end
    check("retire_cnt", retire_cnt, cnt_m);
  endtask

  // Sweep all indices across the three ports with distinct addresses each.
  task automatic check_all(input string tag);
    logic [3:0] a;
    for (int i = 0; i < 16; i++) begin
      a = i[3:0];
      rn_addr = a;
      rm_addr = a + 4'd5;
      rd_addr = a + 4'd11;
      #1;
      check({tag, "_rn"}, rn_data, regs_m[rn_addr]);
      check({tag, "_rm"}, rm_data, regs_m[rm_addr]);
      check({tag, "_rd"}, rd_data, regs_m[rd_addr]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    cnt_m       = '0;
    cur_valid   = 1'b0;
    cur_dest    = '0;
    cur_val     = '0;
    rst_n       = 1'b0;
    wb_en_in    = 1'b0;
    mem_r_en_in = 1'b0;
    dest_in     = '0;
    alu_res_in  = '0;
    mem_res_in  = '0;
    rn_addr     = '0;
    rm_addr     = '0;
    rd_addr     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_all("rst");
    check("rst_cnt", retire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load vs ALU select
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd3, 32'h11, 32'h22);
    commit();
    drive(1'b1, 1'b0, 4'd4, 32'h11, 32'h22);
    commit();

    // Assorted writes to R0..R14
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)), $urandom, $urandom);
      commit();
    end
    drive(1'b1, 1'b0, 4'd0, 32'hA5A5_0000, 32'h0);
    commit();
    drive(1'b1, 1'b1, 4'd14, 32'h0, 32'h1414_1414);
    commit();

    // R15 suppression, including a same-cycle read of 15
    rn_addr = 4'd15;
    drive(1'b1, 1'b0, 4'd15, 32'hDEAD, 32'h0);
    check("r15_same_cycle", rn_data, 32'd0);
    commit();
    rn_addr = 4'd15;
    #1;
    check("r15_read", rn_data, 32'd0);

    // Same-cycle hazard on R7
    drive(1'b1, 1'b0, 4'd7, 32'h5, 32'h0);
    commit();
    rn_addr = 4'd7;
    drive(1'b1, 1'b0, 4'd7, 32'hCAFE, 32'h0);
`ifdef WB_BYPASS_EN
    check("hazard_same", rn_data, 32'hCAFE);
`else
    check("hazard_same", rn_data, 32'h5);
`endif
    commit();

    // Disabled writes with unknown destination
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wb_en_in    = 1'b0;
      dest_in     = 'x;
      mem_r_en_in = 1'($urandom_range(0, 1));
      alu_res_in  = $urandom;
      mem_res_in  = $urandom;
    end
    @(negedge clk);
    check_all("dis");
    check("dis_cnt", retire_cnt, cnt_m);

    // Counter wrap via backdoor preload
    @(negedge clk);
    force dut.retire_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_q;
    cnt_m = 32'hFFFF_FFFE;
    check("wrap_preload", retire_cnt, cnt_m);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'(i + 1), 32'h100 + 32'(i), 32'h0);
      commit();
    end
    check("wrap_final", retire_cnt, 32'd1);

    // Reset asserted during an active write
    @(negedge clk);
    wb_en_in    = 1'b1;
    mem_r_en_in = 1'b0;
    dest_in     = 4'd9;
    alu_res_in  = 32'h1234;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) regs_m[i] = '0;
    cnt_m = '0;
    #1;
    check("rst_mid_cnt", retire_cnt, 32'd0);
    check_all("rst_mid");
    @(negedge clk);
    wb_en_in = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    rn_addr = 4'd9;
    #1;
    check("rst_pending_dropped", rn_data, 32'd0);
    check("rst_release_cnt", retire_cnt, 32'd0);
    drive(1'b1, 1'b0, 4'd9, 32'h77, 32'h0);
    commit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected summary by %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
